// File: rtl/fetch_prefetch_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : fetch_prefetch_pkg                                                |
// | Purpose: Shared types, constants and helpers for the fetch/prefetch stage. |
// |          Provides the queue entry layout {pc, insn}, the default queue     |
// |          depth, the NOP encoding used to fill idle cache data, and a word  |
// |          alignment helper.                                                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fetch_prefetch_pkg;

  localparam int          FETCH_DEPTH_DEFAULT = 2;
  localparam logic [31:0] INSN_NOP            = 32'hE1A0_0000;  // mov r0, r0

  // One prefetch queue entry: fetch address and the instruction word read there.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_prefetch_if.sv
// +----------------------------------------------------------------------------+
// | Module : fetch_prefetch_if                                                 |
// | Purpose: Bundles the fetch stage's I-cache read port, the redirect/stall   |
// |          controls from later stages and the instruction output to Issue.   |
// |          master : the fetch stage itself                                   |
// |          slave  : the environment (I-cache, Issue, redirect source)        |
// |   ic_rd_addr/ic_rd_req        fetch -> cache  word address + request level |
// |   ic_rd_wait/ic_rd_data       cache -> fetch  not-ready flag + read data   |
// |   stall/jmp/jmppc             later stages -> fetch                         |
// |   bubble/insn/pc              fetch -> Issue                                |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fetch_prefetch_if;

  logic [31:0] ic_rd_addr;
  logic        ic_rd_req;
  logic        ic_rd_wait;
  logic [31:0] ic_rd_data;
  logic        stall;
  logic        jmp;
  logic [31:0] jmppc;
  logic        bubble;
  logic [31:0] insn;
  logic [31:0] pc;

  modport master (
    output ic_rd_addr, ic_rd_req,
    input  ic_rd_wait, ic_rd_data,
    input  stall, jmp, jmppc,
    output bubble, insn, pc
  );

  modport slave (
    input  ic_rd_addr, ic_rd_req,
    output ic_rd_wait, ic_rd_data,
    output stall, jmp, jmppc,
    input  bubble, insn, pc
  );

endinterface

`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
// +----------------------------------------------------------------------------+
// | Module : fetch_prefetch_queue                                              |
// | Purpose: DEPTH x WIDTH FIFO holding prefetched {pc, insn} entries.         |
// |          Synchronous clear (flush) has priority over push/pop. Head data   |
// |          is presented combinationally; pointers wrap modulo DEPTH.         |
// |   clk, Nrst           clock, asynchronous active-low reset                 |
// |   i_push/i_push_data  enqueue request and entry                            |
// |   i_pop               dequeue head                                         |
// |   i_clear             discard all entries                                  |
// |   o_head_data         current head entry                                   |
// |   o_count             occupancy, 0..DEPTH                                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_prefetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     Nrst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_clear,
  output logic [WIDTH-1:0]         o_head_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // Guard against overflow/underflow so the pointers can never skew.
  assign w_do_push = i_push && (r_count != c_FULL);
  assign w_do_pop  = i_pop  && (r_count != '0);

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (w_do_push) r_tail <= r_tail + 1'b1;
      if (w_do_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + c_CNT_W'(w_do_push) - c_CNT_W'(w_do_pop);
    end
  end

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_tail] <= i_push_data;
  end

  assign o_head_data = r_mem[r_head];
  assign o_count     = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_prefetch.sv
// +----------------------------------------------------------------------------+
// | Module : fetch_prefetch                                                    |
// | Purpose: Instruction fetch stage with a small prefetch queue. Streams      |
// |          sequential word addresses to the I-cache, buffers returned words, |
// |          and presents one {insn, pc, bubble} per cycle to Issue. A taken   |
// |          jmp flushes all prefetched work and redirects to jmppc.           |
// |   clk, Nrst  clock, asynchronous active-low reset                          |
// |   bus        fetch_prefetch_if.master (cache port, controls, Issue output) |
// |   DEPTH      prefetch queue entries (power of two, 2..8)                   |
// |   RESET_PC   fetch address after reset                                     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int          DEPTH    = FETCH_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             Nrst,
  fetch_prefetch_if.master bus
);

  localparam int c_CNT_W = $clog2(DEPTH) + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [31:0]        r_fetch_pc;
  logic               r_bubble;
  logic [31:0]        r_insn;
  logic [31:0]        r_pc;

  logic               w_req;
  logic               w_accept;
  logic               w_pop;
  logic [c_CNT_W-1:0] w_count;
  fetch_entry_t       w_head;
  fetch_entry_t       w_push_entry;
  logic               w_bubble_nxt;
  logic [31:0]        w_insn_nxt;
  logic [31:0]        w_pc_nxt;

  // Request only when a returned word is guaranteed a slot; a jmp cycle never
  // requests, so cache data completing alongside a redirect is dropped.
  assign w_req        = !bus.jmp && (w_count < c_FULL);
  assign w_accept     = w_req && !bus.ic_rd_wait;
  assign w_pop        = !bus.jmp && !bus.stall && (w_count != '0);
  assign w_push_entry = '{pc: r_fetch_pc, insn: bus.ic_rd_data};

  fetch_prefetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_queue (
    .clk         (clk),
    .Nrst        (Nrst),
    .i_push      (w_accept),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_clear     (bus.jmp),
    .o_head_data (w_head),
    .o_count     (w_count)
  );

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      r_fetch_pc <= word_align(RESET_PC);
    end else if (bus.jmp) begin
      r_fetch_pc <= word_align(bus.jmppc);
    end else if (w_accept) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  // Output register priority: redirect, then stall, then dequeue, else bubble.
  // insn/pc hold whenever no new entry is loaded.
  always_comb begin
    w_bubble_nxt = r_bubble;
    w_insn_nxt   = r_insn;
    w_pc_nxt     = r_pc;
    if (bus.jmp) begin
      w_bubble_nxt = 1'b1;
    end else if (bus.stall) begin
      w_bubble_nxt = r_bubble;
    end else if (w_count != '0) begin
      w_bubble_nxt = 1'b0;
      w_insn_nxt   = w_head.insn;
      w_pc_nxt     = w_head.pc;
    end else begin
      w_bubble_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      r_bubble <= 1'b1;
      r_insn   <= '0;
      r_pc     <= '0;
    end else begin
      r_bubble <= w_bubble_nxt;
      r_insn   <= w_insn_nxt;
      r_pc     <= w_pc_nxt;
    end
  end

  assign bus.ic_rd_addr = r_fetch_pc;
  assign bus.ic_rd_req  = w_req;
  assign bus.bubble     = r_bubble;
  assign bus.insn       = r_insn;
  assign bus.pc         = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_prefetch.sv
// +----------------------------------------------------------------------------+
// | Module : tb_fetch_prefetch                                                 |
// | Purpose: Self-checking bench for fetch_prefetch. A queue-level reference   |
// |          model tracks fetch address, buffered {pc, insn} entries and the   |
// |          Issue-facing outputs; a compare process checks the DUT against it |
// |          every cycle. Directed scenarios pin literal values, then a        |
// |          randomized phase exercises jmp/stall/wait/reset mixes. A second   |
// |          instance with RESET_PC near the top of memory checks wrap-around.|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_prefetch;
  import fetch_prefetch_pkg::*;

  localparam int DEPTH = 2;

  logic clk;
  logic Nrst;

  fetch_prefetch_if fp ();
  fetch_prefetch_if fp2 ();

  fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk  (clk),
    .Nrst (Nrst),
    .bus  (fp)
  );

  fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .clk  (clk),
    .Nrst (Nrst),
    .bus  (fp2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache contents are a fixed function of the address; idle cycles carry a NOP.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  assign fp.ic_rd_data  = fp.ic_rd_wait  ? INSN_NOP : mem_word(fp.ic_rd_addr);
  assign fp2.ic_rd_data = fp2.ic_rd_wait ? INSN_NOP : mem_word(fp2.ic_rd_addr);

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_fetch_pc;
  logic [63:0] m_q[$];
  logic        m_bubble;
  logic [31:0] m_insn;
  logic [31:0] m_pc;
  bit          m_acc;
  logic [63:0] m_ent;

  always @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      m_fetch_pc = 32'h0;
      m_q.delete();
      m_bubble = 1'b1;
      m_insn   = 32'h0;
      m_pc     = 32'h0;
    end else begin
      m_acc = !fp.jmp && (m_q.size() < DEPTH) && !fp.ic_rd_wait;
      if (fp.jmp) begin
        m_bubble   = 1'b1;
        m_q.delete();
        m_fetch_pc = fp.jmppc & ~32'h3;
      end else begin
        // Dequeue sees the queue as it was before this cycle's arrival.
        if (!fp.stall) begin
          if (m_q.size() > 0) begin
            m_ent    = m_q.pop_front();
            m_pc     = m_ent[63:32];
            m_insn   = m_ent[31:0];
            m_bubble = 1'b0;
          end else begin
            m_bubble = 1'b1;
          end
        end
        if (m_acc) begin
          m_q.push_back({m_fetch_pc, mem_word(m_fetch_pc)});
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("bubble", 32'(fp.bubble), 32'(m_bubble));
      check("insn", fp.insn, m_insn);
      check("pc", fp.pc, m_pc);
      check("ic_rd_req", 32'(fp.ic_rd_req), 32'(!fp.jmp && (m_q.size() < DEPTH)));
      check("ic_rd_addr", fp.ic_rd_addr, m_fetch_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit j, input logic [31:0] jp, input bit s, input bit w);
    #1;
    fp.jmp        = j;
    fp.jmppc      = jp;
    fp.stall      = s;
    fp.ic_rd_wait = w;
  endtask

  initial begin
    Nrst = 1'b0;
    fp.jmp = 1'b0;  fp.jmppc = 32'h0;  fp.stall = 1'b0;  fp.ic_rd_wait = 1'b0;
    fp2.jmp = 1'b0; fp2.jmppc = 32'h0; fp2.stall = 1'b0; fp2.ic_rd_wait = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_bubble", 32'(fp.bubble), 32'd1);
    check("rst_insn", fp.insn, 32'h0);
    check("rst_pc", fp.pc, 32'h0);
    Nrst   = 1'b1;
    chk_en = 1'b1;

    // Sequential stream from reset: one bubble cycle after release, then 0,4,8.
    @(negedge clk);
    check("start_bubble", 32'(fp.bubble), 32'd1);
    check("hi_start_bubble", 32'(fp2.bubble), 32'd1);
    @(negedge clk);
    check("seq0_bubble", 32'(fp.bubble), 32'd0);
    check("seq0_pc", fp.pc, 32'h0);
    check("seq0_insn", fp.insn, mem_word(32'h0));
    check("hi_seq0_pc", fp2.pc, 32'hFFFF_FFF8);
    @(negedge clk);
    check("seq1_pc", fp.pc, 32'h4);
    check("hi_seq1_pc", fp2.pc, 32'hFFFF_FFFC);
    @(negedge clk);
    check("seq2_pc", fp.pc, 32'h8);
    check("hi_wrap_pc", fp2.pc, 32'h0);
    check("hi_wrap_insn", fp2.insn, mem_word(32'h0));

    // Stall three cycles: queue fills, request drops, outputs frozen.
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("stall_pc", fp.pc, 32'h8);
      check("stall_req", 32'(fp.ic_rd_req), 32'd0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("unstall_pc", fp.pc, 32'hC);
    check("unstall_req", 32'(fp.ic_rd_req), 32'd1);

    // Cache wait for five cycles: queue drains to bubbles, address held.
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("wait_bubble", 32'(fp.bubble), 32'd1);
    check("wait_req", 32'(fp.ic_rd_req), 32'd1);
    check("wait_addr", fp.ic_rd_addr, 32'h14);

    // Redirect to an unaligned target.
    drive(1'b1, 32'h0000_1003, 1'b0, 1'b0);
    @(negedge clk);
    check("jmp_bubble", 32'(fp.bubble), 32'd1);
    check("jmp_addr", fp.ic_rd_addr, 32'h1000);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("jmp_bubble2", 32'(fp.bubble), 32'd1);
    @(negedge clk);
    check("jmp_pc", fp.pc, 32'h1000);
    check("jmp_insn", fp.insn, mem_word(32'h1000));
    check("jmp_valid", 32'(fp.bubble), 32'd0);

    // Redirect during stall with a full queue: stale entries must vanish.
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("full_req", 32'(fp.ic_rd_req), 32'd0);
    drive(1'b1, 32'h0000_2000, 1'b1, 1'b0);
    @(negedge clk);
    check("jstall_bubble", 32'(fp.bubble), 32'd1);
    check("jstall_pc_hold", fp.pc, 32'h1000);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("jstall_bubble2", 32'(fp.bubble), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("jstall_pc", fp.pc, 32'h2000);
    check("jstall_valid", 32'(fp.bubble), 32'd0);

    // Asynchronous reset mid-stream takes effect without a clock edge.
    #1 Nrst = 1'b0;
    #1;
    check("async_bubble", 32'(fp.bubble), 32'd1);
    check("async_pc", fp.pc, 32'h0);
    check("async_insn", fp.insn, 32'h0);
    check("async_addr", fp.ic_rd_addr, 32'h0);
    @(negedge clk);
    #1 Nrst = 1'b1;

    // Randomized mix of redirects, stalls, cache waits and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) begin
        #1 Nrst = 1'b0;
        @(negedge clk);
        #1 Nrst = 1'b1;
      end else begin
        drive(($urandom_range(0, 19) == 0), $urandom,
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 3));
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
